// File: rtl/apb_pkg.sv
// Shared definitions for APB completers.
//   apb_state_e : completer transfer FSM states (IDLE/WAIT/RESP)
//   strb_width  : byte-lane count for a given data width
//   byte_merge  : merge new bytes into an old word under a byte strobe
// byte_merge works on a fixed maximum width; callers zero-extend their
// operands and truncate the result back to their own data width.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

  localparam int MaxDataWidth = 256;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic logic [MaxDataWidth-1:0] byte_merge(
    input logic [MaxDataWidth-1:0]   old_word,
    input logic [MaxDataWidth-1:0]   new_word,
    input logic [MaxDataWidth/8-1:0] strb
  );
    logic [MaxDataWidth-1:0] res;
    res = old_word;
    for (int b = 0; b < MaxDataWidth/8; b++)
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter used to time APB wait states.
//   PCLK, reset : clock, async active-high reset
//   load        : load load_val (takes priority over en)
//   load_val    : number of wait cycles to count
//   en          : decrement by one (saturates at 0)
//   done        : count is 1, i.e. this is the last wait cycle
module apb_wait_counter (
  input  logic       PCLK,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with a bank of Depth byte-strobed read/write registers and
// a fixed number of wait states.
//   PCLK, reset         : clock, async active-high reset
//   PSEL, PENABLE       : requester select / access phase
//   PWRITE, PADDR       : direction, byte address
//   PWDATA, PSTRB       : write data, byte-lane enables
//   PREADY              : high for exactly the completing access cycle
//   PRDATA              : read data, valid only while PREADY is high
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 16,
  parameter int WaitStates = 0
) (
  input  logic                   PCLK,
  input  logic                   reset,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [AddrWidth-1:0]   PADDR,
  input  logic [DataWidth-1:0]   PWDATA,
  input  logic [DataWidth/8-1:0] PSTRB,
  output logic                   PREADY,
  output logic [DataWidth-1:0]   PRDATA
);

  localparam int StrbWidth = strb_width(DataWidth);
  localparam int OffW      = $clog2(StrbWidth);
  localparam int IdxW      = $clog2(Depth);

  apb_state_e state_q, state_d;
  logic [DataWidth-1:0]            prdata_q, prdata_d;
  logic [Depth-1:0][DataWidth-1:0] regs_q, regs_d;

  logic            cnt_load, cnt_en, cnt_done;
  logic [IdxW-1:0] idx;
  logic            hit;
  logic [DataWidth-1:0] rd_word;

  // Byte offset bits are dropped; anything above the index must be zero.
  assign idx = PADDR[OffW +: IdxW];
  assign hit = ((PADDR >> (OffW + IdxW)) == '0);

  apb_wait_counter u_wait_cnt (
    .PCLK     (PCLK),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (4'(WaitStates)),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    prdata_d = prdata_q;
    regs_d   = regs_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    rd_word  = (!PWRITE && hit) ? regs_q[idx] : '0;

    case (state_q)
      ST_IDLE: begin
        // PSEL with PENABLE already high is not a setup phase; ignore it.
        if (PSEL && !PENABLE) begin
          if (WaitStates == 0) begin
            state_d  = ST_RESP;
            prdata_d = rd_word;
          end else begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d  = ST_IDLE;
          prdata_d = '0;
        end else if (cnt_done) begin
          state_d  = ST_RESP;
          prdata_d = rd_word;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        // Write commits here, after PRDATA was loaded, so a transfer never
        // reads back its own write.
        state_d  = ST_IDLE;
        prdata_d = '0;
        if (PWRITE && hit)
          regs_d[idx] = DataWidth'(byte_merge(MaxDataWidth'(regs_q[idx]),
                                              MaxDataWidth'(PWDATA),
                                              (MaxDataWidth/8)'(PSTRB)));
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prdata_q <= '0;
      regs_q   <= '0;
    end else begin
      state_q  <= state_d;
      prdata_q <= prdata_d;
      regs_q   <= regs_d;
    end
  end

  assign PREADY = (state_q == ST_RESP);
  assign PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: four completers with WaitStates 0..3 share
// one APB bus, each with its own PSEL. A per-device array model tracks the
// register contents from the transfer rules alone.
module tb_apb_completer_regs;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       psel = '0;
  logic             penable = 1'b0;
  logic             pwrite = 1'b0;
  logic [31:0]      paddr = '0;
  logic [31:0]      pwdata = '0;
  logic [3:0]       pstrb = '0;
  logic [3:0]       pready;
  logic [3:0][31:0] prdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_setup = 0;
  logic [31:0] mdl [4][16];
  logic [31:0] rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb_completer_regs #(.WaitStates(g)) u_dut (
      .PCLK    (clk),
      .reset   (rst),
      .PSEL    (psel[g]),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PREADY  (pready[g]),
      .PRDATA  (prdata[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
  endtask

  // One complete transfer on device d, followed by an idle cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata);
    bit          hit;
    int          idx;
    logic [31:0] exp_rd;
    hit    = addr < 64;
    idx    = (addr / 4) % 16;
    exp_rd = (!wr && hit) ? mdl[d][idx] : 32'h0;
    @(posedge clk); #1;
    last_setup = cyc;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 0; c <= d; c++) begin
      chk($sformatf("pready_d%0d_acc%0d", d, c), 32'(pready[d]), 32'(c == d));
      if (c < d) begin @(posedge clk); #1; end
    end
    rdata = prdata[d];
    chk($sformatf("prdata_d%0d_a%0h", d, addr), prdata[d], exp_rd);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0;
    chk("pready_after", 32'(pready[d]), 32'h0);
    chk("prdata_after", prdata[d], 32'h0);
    if (wr && hit)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
  endtask

  initial begin
    mdl_clear();
    #2;
    for (int d = 0; d < 4; d++) begin
      chk("reset_pready", 32'(pready[d]), 32'h0);
      chk("reset_prdata", prdata[d], 32'h0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Write then read, no wait states.
    xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, rd);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, rd);
    chk("wr_rd_literal", rd, 32'hDEADBEEF);

    // Byte strobes.
    xfer(0, 1, 32'h04, 32'h11223344, 4'hF, rd);
    xfer(0, 1, 32'h04, 32'hAABBCCDD, 4'b0101, rd);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, rd);
    chk("strobe_literal", rd, 32'h11BB33DD);

    // Three wait states.
    xfer(3, 1, 32'h0C, 32'hCAFEF00D, 4'hF, rd);
    xfer(3, 0, 32'h0C, 32'h0, 4'h0, rd);
    chk("ws3_literal", rd, 32'hCAFEF00D);

    // Out-of-range address, including an offset alias.
    xfer(0, 1, 32'h40, 32'h12345678, 4'hF, rd);
    xfer(0, 0, 32'h40, 32'h0, 4'h0, rd);
    chk("oor_rd", rd, 32'h0);
    xfer(0, 0, 32'h41, 32'h0, 4'h0, rd);
    chk("oor_alias", rd, 32'h0);
    for (int i = 0; i < 16; i++) xfer(0, 0, 32'(i * 4), 32'h0, 4'h0, rd);

    // Access phase with no setup phase is ignored.
    @(posedge clk); #1 psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 32'h0; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("no_setup_pready", 32'(pready[0]), 32'h0);
    end
    psel[0] = 1'b0; penable = 1'b0;
    xfer(0, 0, 32'h0, 32'h0, 4'h0, rd);

    // Back-to-back alternating writes and reads, one wait state.
    for (int i = 0; i < 8; i++) begin
      int t_prev;
      xfer(1, 1, 32'(i * 4), $urandom, 4'hF, rd);
      t_prev = last_setup;
      xfer(1, 0, 32'(i * 4), 32'h0, 4'h0, rd);
      chk("b2b_period", 32'(last_setup - t_prev), 32'd4);
      chk("b2b_data", rd, mdl[1][i]);
    end

    // Abort: PSEL drops during WAIT; no response, no write.
    xfer(2, 1, 32'h10, 32'h55AA55AA, 4'hF, rd);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'h01020304; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("abort_pready", 32'(pready[2]), 32'h0);
      @(posedge clk); #1;
    end
    penable = 1'b0;
    xfer(2, 0, 32'h10, 32'h0, 4'h0, rd);
    chk("abort_literal", rd, 32'h55AA55AA);

    // Randomized traffic against the model.
    for (int n = 0; n < 250; n++) begin
      int          d;
      bit          wr;
      logic [31:0] a;
      d  = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 75));
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), rd);
    end
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 16; i++) xfer(d, 0, 32'(i * 4), 32'h0, 4'h0, rd);

    // Reset in the middle of a write's WAIT.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'h89ABCDEF; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_mid_pready", 32'(pready[d]), 32'h0);
      chk("rst_mid_prdata", prdata[d], 32'h0);
    end
    mdl_clear();
    @(posedge clk); #1;
    psel = '0; penable = 1'b0; rst = 1'b0;
    xfer(2, 0, 32'h10, 32'h0, 4'h0, rd);
    chk("rst_readback", rd, 32'h0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
